// File: rtl/ctrl_plane_seq_pkg.sv
// ctrl_plane_seq_pkg: shared table geometry, sequencer state enum and row-limit helper
package ctrl_plane_seq_pkg;
  localparam int num_col = 5;
  localparam int phit_size = 64;
  localparam int dwidth_RFadd = 5;
  localparam int dwidth_iter = 8;
  localparam int cwidth = $clog2(num_col);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;
  function automatic logic [dwidth_RFadd-1:0] row_max_of(input logic [dwidth_RFadd:0] n);
    logic [dwidth_RFadd:0] m;
    m = n[dwidth_RFadd] ? {1'b0, {dwidth_RFadd{1'b1}}} : n - 1'b1;
    return m[dwidth_RFadd-1:0];
  endfunction
endpackage

// File: rtl/ctrl_plane_addr_gen.sv
// ctrl_plane_addr_gen: two-level wrapping counter (inner wraps into outer) with terminal flag
module ctrl_plane_addr_gen #(
  parameter int iw = 3,
  parameter int ow = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          step,
  input  logic [iw-1:0] inner_max,
  input  logic [ow-1:0] outer_max,
  output logic [iw-1:0] inner,
  output logic [ow-1:0] outer,
  output logic          last
);
  logic inner_end;
  assign inner_end = inner == inner_max;
  assign last = inner_end && outer == outer_max;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      inner <= '0;
      outer <= '0;
    end else if (clr) begin
      inner <= '0;
      outer <= '0;
    end else if (step) begin
      inner <= inner_end ? '0 : inner + 1'b1;
      outer <= inner_end ? outer + 1'b1 : outer;
    end
endmodule

// File: rtl/ctrl_plane_seq.sv
// ctrl_plane_seq: LOAD/RUN sequencer for the control-plane tables; CTRL_PLANE_SEQ_STALL_CNT_EN adds stall_cnt
module ctrl_plane_seq
  import ctrl_plane_seq_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_start,
  input  logic                    run_start,
  input  logic [dwidth_RFadd:0]   num_rows,
  input  logic [dwidth_iter-1:0]  run_iters,
  input  logic [phit_size-1:0]    in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    adv,
  output logic [dwidth_RFadd-1:0] wr_add,
  output logic [num_col-1:0]      wr_en,
  output logic [phit_size-1:0]    wr_data,
  output logic [dwidth_RFadd-1:0] rd_add,
  output logic                    rd_valid,
  output logic                    busy,
  output logic                    done
`ifdef CTRL_PLANE_SEQ_STALL_CNT_EN
  ,
  output logic [31:0]             stall_cnt
`endif
);
  state_t state;
  logic [dwidth_RFadd-1:0] rows_m1;
  logic [dwidth_iter-1:0] iters_m1;
  logic [cwidth-1:0] ld_col;
  logic [dwidth_RFadd-1:0] ld_row;
  logic [dwidth_iter-1:0] rn_iter_unused;
  logic ld_go, rn_go, hs, rn_step, ld_last, rn_last;
  assign in_ready = state == LOAD;
  assign busy = state != IDLE;
  assign ld_go = state == IDLE && load_start;
  assign rn_go = state == IDLE && run_start && !load_start;
  assign hs = in_valid && in_ready;
  assign rn_step = state == RUN && adv;
  ctrl_plane_addr_gen #(.iw(cwidth), .ow(dwidth_RFadd)) u_ld_gen (
    .clk(clk), .rst(rst), .clr(ld_go), .step(hs),
    .inner_max(cwidth'(num_col - 1)), .outer_max(rows_m1),
    .inner(ld_col), .outer(ld_row), .last(ld_last)
  );
  ctrl_plane_addr_gen #(.iw(dwidth_RFadd), .ow(dwidth_iter)) u_rn_gen (
    .clk(clk), .rst(rst), .clr(rn_go), .step(rn_step),
    .inner_max(rows_m1), .outer_max(iters_m1),
    .inner(rd_add), .outer(rn_iter_unused), .last(rn_last)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      rows_m1 <= '0;
      iters_m1 <= '0;
      wr_add <= '0;
      wr_en <= '0;
      wr_data <= '0;
      rd_valid <= 1'b0;
      done <= 1'b0;
    end else begin
      wr_en <= '0;
      rd_valid <= rn_step;
      done <= state == DRAIN;
      case (state)
        IDLE: begin
          if (ld_go || rn_go) begin
            rows_m1 <= row_max_of(num_rows);
            state <= num_rows == '0 ? DRAIN : ld_go ? LOAD : RUN;
          end
          if (rn_go) iters_m1 <= run_iters == '0 ? '0 : run_iters - 1'b1;
        end
        LOAD: if (hs) begin
          wr_en <= num_col'(1) << ld_col;
          wr_add <= ld_row;
          wr_data <= in_data;
          state <= ld_last ? DRAIN : LOAD;
        end
        RUN: if (rn_step && rn_last) state <= DRAIN;
        default: state <= IDLE;
      endcase
    end
`ifdef CTRL_PLANE_SEQ_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) stall_cnt <= '0;
    else if (ld_go || rn_go) stall_cnt <= '0;
    else if (((state == RUN && !adv) || (state == LOAD && !in_valid)) && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
`endif
endmodule
